// File: rtl/signed_minmax_seq.sv
// Batch reducer: accepts N signed W-bit samples over valid/ready and reports
// the running maximum, the running minimum and the first index of the maximum.
module signed_minmax_seq #(
  parameter int W = 3,
  parameter int N = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 in_valid,
  input  logic [W-1:0]                         in_data,
  output logic                                 in_ready,
  output logic                                 busy,
  output logic                                 done,
  output logic [W-1:0]                         max_out,
  output logic [W-1:0]                         min_out,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] max_idx
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [IW-1:0] cnt_r;
  logic          accept_s;
  logic          last_s;

  assign accept_s = in_valid & in_ready;
  assign last_s   = accept_s & (cnt_r == IW'(N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; start only matters in IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COLLECT: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
      end
      COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        done     = 1'b0;
      end
      DONE: begin
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
      end
    endcase
  end

  // Sample counter, cleared when a batch begins
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if ((state_r == IDLE) && start) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= cnt_r + IW'(1);
    end
  end

  // Running extremes; strict greater-than keeps the earliest index on ties
  always_ff @(posedge clk) begin
    if (rst) begin
      max_out <= '0;
      min_out <= '0;
      max_idx <= '0;
    end else if (accept_s) begin
      if (cnt_r == IW'(0)) begin
        max_out <= in_data;
        min_out <= in_data;
        max_idx <= '0;
      end else begin
        if ($signed(in_data) > $signed(max_out)) begin
          max_out <= in_data;
          max_idx <= cnt_r;
        end
        if ($signed(in_data) < $signed(min_out)) begin
          min_out <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_signed_minmax_seq.sv
// Directed bench for signed_minmax_seq (W=3, N=4) with hand-computed expectations.
module tb_signed_minmax_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [2:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [2:0] max_out;
  logic [2:0] min_out;
  logic [1:0] max_idx;

  int n_cmp = 0;
  int n_err = 0;

  signed_minmax_seq #(.W(3), .N(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .max_out  (max_out),
    .min_out  (min_out),
    .max_idx  (max_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [2:0] emax, input logic [1:0] eidx,
                           input logic [2:0] emin);
    check({tag, "_max"}, {5'd0, max_out}, {5'd0, emax});
    check({tag, "_idx"}, {6'd0, max_idx}, {6'd0, eidx});
    check({tag, "_min"}, {5'd0, min_out}, {5'd0, emin});
  endtask

  // Start a batch and feed four samples (listed first-to-last in v), with gap idle cycles
  // after each of the first three; ends one cycle after the last accept (state DONE).
  task automatic batch(input string tag, input logic [11:0] v, input int gap, input logic vs);
    start    = 1'b1;
    in_valid = vs;
    in_data  = 3'd2;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check({tag, "_ready"}, {7'd0, in_ready}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v[11 - 3 * i -: 3];
      tick();
      in_valid = 1'b0;
      if (i < 3) begin
        check({tag, "_nodone"}, {7'd0, done}, 8'd0);
        for (int g = 0; g < gap; g++) begin
          tick();
          check({tag, "_gapready"}, {7'd0, in_ready}, 8'd1);
        end
      end
    end
    check({tag, "_done"}, {7'd0, done}, 8'd1);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 3'd0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", {7'd0, in_ready}, 8'd0);
    check("rst_busy",  {7'd0, busy},     8'd0);
    check("rst_done",  {7'd0, done},     8'd0);
    check_res("rst", 3'd0, 2'd0, 3'd0);

    // 1: back-to-back 3,1,-1,2
    batch("t1", {3'd3, 3'd1, 3'b111, 3'd2}, 0, 1'b0);
    check_res("t1", 3'd3, 2'd0, 3'b111);
    tick();
    check("t1_pulse",  {7'd0, done}, 8'd0);
    check("t1_idle",   {7'd0, busy}, 8'd0);
    check_res("t1_hold", 3'd3, 2'd0, 3'b111);

    // 2: -2,-1,-3,-4 with two-cycle gaps
    batch("t2", {3'b110, 3'b111, 3'b101, 3'b100}, 2, 1'b0);
    check_res("t2", 3'b111, 2'd1, 3'b100);
    tick();

    // 3: ties
    batch("t3a", {3'd2, 3'd2, 3'b100, 3'd2}, 0, 1'b0);
    check_res("t3a", 3'd2, 2'd0, 3'b100);
    tick();
    batch("t3b", {3'b101, 3'b101, 3'b101, 3'b101}, 0, 1'b0);
    check_res("t3b", 3'b101, 2'd0, 3'b101);
    tick();

    // 4: start during COLLECT and DONE ignored; 1,0,-2,1
    start = 1'b1;
    tick();
    check("t4_ready", {7'd0, in_ready}, 8'd1);
    in_valid = 1'b1;
    in_data  = 3'd1;
    tick();
    in_data = 3'd0;
    tick();
    in_data = 3'b110;
    tick();
    in_data = 3'd1;
    tick();
    in_valid = 1'b0;
    check("t4_done", {7'd0, done}, 8'd1);
    check_res("t4", 3'd1, 2'd0, 3'b110);
    tick();
    start = 1'b0;
    check("t4_nostart_busy",  {7'd0, busy},     8'd0);
    check("t4_nostart_ready", {7'd0, in_ready}, 8'd0);
    in_valid = 1'b1;
    in_data  = 3'd3;
    tick();
    check("t4_idle_ready", {7'd0, in_ready}, 8'd0);
    tick();
    in_valid = 1'b0;
    check("t4_idle_done", {7'd0, done}, 8'd0);
    check_res("t4_idle", 3'd1, 2'd0, 3'b110);

    // 5: reset after two accepts, then restart with in_valid alongside start
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 3'd1;
    tick();
    in_data = 3'd3;
    tick();
    in_valid = 1'b0;
    check_res("t5_partial", 3'd3, 2'd1, 3'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_busy",  {7'd0, busy},     8'd0);
    check("t5_rst_ready", {7'd0, in_ready}, 8'd0);
    check("t5_rst_done",  {7'd0, done},     8'd0);
    check_res("t5_rst", 3'd0, 2'd0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_nodone", {7'd0, done}, 8'd0);
    end
    batch("t5", {3'd1, 3'b100, 3'd3, 3'd0}, 0, 1'b1);
    check_res("t5", 3'd3, 2'd2, 3'b100);
    tick();

    // 6: full range -4,3,-4,3 and done width
    batch("t6", {3'b100, 3'd3, 3'b100, 3'd3}, 1, 1'b0);
    check_res("t6", 3'd3, 2'd1, 3'b100);
    tick();
    check("t6_pulse", {7'd0, done}, 8'd0);
    tick();
    check("t6_after", {7'd0, done}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
